// File: rtl/decode_pkg.sv
// Shared decode constants for the D-stage hazard unit: opcodes, functs,
// Tuse/Tnew encodings and the instruction-class enumeration.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR  = 6'h08;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef logic [1:0] tuse_t;
    typedef logic [1:0] tnew_t;

    localparam tuse_t TUSE_0    = 2'd0;
    localparam tuse_t TUSE_1    = 2'd1;
    localparam tuse_t TUSE_2    = 2'd2;
    // Field is not read; larger than any Tnew so it can never hazard.
    localparam tuse_t TUSE_NONE = 2'd3;

    localparam tnew_t TNEW_0 = 2'd0;
    localparam tnew_t TNEW_1 = 2'd1;
    localparam tnew_t TNEW_2 = 2'd2;

    typedef enum logic [3:0] {
        ClsNop, ClsAdd, ClsSub, ClsJr, ClsOri,
        ClsLw, ClsSw, ClsBeq, ClsLui, ClsJal
    } instr_class_e;

    // One stage further down the pipe: result is one cycle closer.
    function automatic tnew_t tnew_dec(input tnew_t t);
        return (t == TNEW_0) ? TNEW_0 : tnew_t'(t - 2'd1);
    endfunction

endpackage

// File: rtl/decode_hazard_pipe_if.sv
// D-stage bus between the pipeline front end and the hazard unit.
interface decode_hazard_pipe_if #(
    parameter int DEPTH = 3,
    parameter int SELW  = $clog2(DEPTH + 1)
);
    logic [31:0]     instr;
    logic            valid_in;
    logic            flush;
    logic            stall;
    logic [SELW-1:0] fwd_rs;
    logic [SELW-1:0] fwd_rt;
    logic            illegal;
    logic [4:0]      a3_d;

    modport master (
        output instr, valid_in, flush,
        input  stall, fwd_rs, fwd_rt, illegal, a3_d
    );

    modport slave (
        input  instr, valid_in, flush,
        output stall, fwd_rs, fwd_rt, illegal, a3_d
    );
endinterface

// File: rtl/instr_class_dec.sv
// Combinational classifier: instruction word -> class, destination,
// per-field Tuse, Tnew at E and illegal flag.
module instr_class_dec
    import decode_pkg::*;
(
    input  logic [31:0]  instr_i,
    output instr_class_e cls_o,
    output logic [4:0]   a3_o,
    output tuse_t        rs_tuse_o,
    output tuse_t        rt_tuse_o,
    output tnew_t        tnew_o,
    output logic         illegal_o
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;

    assign opcode = instr_i[31:26];
    assign rt     = instr_i[20:16];
    assign rd     = instr_i[15:11];
    assign funct  = instr_i[5:0];

    // Decode; anything unrecognised falls back to nop with illegal set.
    always_comb begin
        cls_o     = ClsNop;
        a3_o      = REG_ZERO;
        rs_tuse_o = TUSE_NONE;
        rt_tuse_o = TUSE_NONE;
        tnew_o    = TNEW_0;
        illegal_o = 1'b0;
        if (instr_i != 32'd0) begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        FUNCT_ADD, FUNCT_SUB: begin
                            cls_o     = (funct == FUNCT_ADD) ? ClsAdd : ClsSub;
                            a3_o      = rd;
                            rs_tuse_o = TUSE_1;
                            rt_tuse_o = TUSE_1;
                            tnew_o    = TNEW_1;
                        end
                        FUNCT_JR: begin
                            cls_o     = ClsJr;
                            rs_tuse_o = TUSE_0;
                        end
                        default: illegal_o = 1'b1;
                    endcase
                end
                OP_ORI: begin
                    cls_o     = ClsOri;
                    a3_o      = rt;
                    rs_tuse_o = TUSE_1;
                    tnew_o    = TNEW_1;
                end
                OP_LW: begin
                    cls_o     = ClsLw;
                    a3_o      = rt;
                    rs_tuse_o = TUSE_1;
                    tnew_o    = TNEW_2;
                end
                OP_SW: begin
                    cls_o     = ClsSw;
                    rs_tuse_o = TUSE_1;
                    rt_tuse_o = TUSE_2;
                end
                OP_BEQ: begin
                    cls_o     = ClsBeq;
                    rs_tuse_o = TUSE_0;
                    rt_tuse_o = TUSE_0;
                end
                OP_LUI: begin
                    cls_o  = ClsLui;
                    a3_o   = rt;
                    tnew_o = TNEW_1;
                end
                OP_JAL: begin
                    cls_o  = ClsJal;
                    a3_o   = REG_RA;
                    tnew_o = TNEW_0;
                end
                default: illegal_o = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/decode_hazard_pipe.sv
// D-stage hazard unit: tracks {a3, tnew} for DEPTH downstream stages and
// produces stall and forward selects for the instruction in D.
module decode_hazard_pipe
    import decode_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int SELW  = $clog2(DEPTH + 1)
) (
    input logic                 clk,
    input logic                 reset,
    decode_hazard_pipe_if.slave bus
);
    instr_class_e dec_cls;
    logic [4:0]   dec_a3;
    tuse_t        dec_rs_tuse;
    tuse_t        dec_rt_tuse;
    tnew_t        dec_tnew;
    logic         dec_illegal;

    instr_class_dec u_dec (
        .instr_i   (bus.instr),
        .cls_o     (dec_cls),
        .a3_o      (dec_a3),
        .rs_tuse_o (dec_rs_tuse),
        .rt_tuse_o (dec_rt_tuse),
        .tnew_o    (dec_tnew),
        .illegal_o (dec_illegal)
    );

    logic [4:0] st_a3_q   [DEPTH];
    logic [4:0] st_a3_d   [DEPTH];
    tnew_t      st_tnew_q [DEPTH];
    tnew_t      st_tnew_d [DEPTH];

    logic [4:0]      rs_f, rt_f;
    tuse_t           rs_tuse_eff, rt_tuse_eff;
    logic            rs_hit, rt_hit;
    logic [SELW-1:0] rs_k, rt_k;
    tnew_t           rs_tn, rt_tn;
    logic            stall;
    logic            bubble;

    assign rs_f = bus.instr[25:21];
    assign rt_f = bus.instr[20:16];

    // An invalid D slot reads nothing, so it can never stall.
    assign rs_tuse_eff = bus.valid_in ? dec_rs_tuse : TUSE_NONE;
    assign rt_tuse_eff = bus.valid_in ? dec_rt_tuse : TUSE_NONE;

    // Nearest matching stage per field; scanning outward-in lets smallest k win.
    always_comb begin
        rs_hit = 1'b0;
        rs_k   = '0;
        rs_tn  = TNEW_0;
        rt_hit = 1'b0;
        rt_k   = '0;
        rt_tn  = TNEW_0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (st_a3_q[i] != REG_ZERO && st_a3_q[i] == rs_f) begin
                rs_hit = 1'b1;
                rs_k   = SELW'(i + 1);
                rs_tn  = st_tnew_q[i];
            end
            if (st_a3_q[i] != REG_ZERO && st_a3_q[i] == rt_f) begin
                rt_hit = 1'b1;
                rt_k   = SELW'(i + 1);
                rt_tn  = st_tnew_q[i];
            end
        end
    end

    // Stall when the producer is still further away than the consumer's use.
    assign stall = (rs_hit && rs_tuse_eff != TUSE_NONE && rs_tuse_eff < rs_tn) ||
                   (rt_hit && rt_tuse_eff != TUSE_NONE && rt_tuse_eff < rt_tn);

    assign bus.stall   = stall;
    assign bus.fwd_rs  = (rs_hit && rs_tn == TNEW_0) ? rs_k : '0;
    assign bus.fwd_rt  = (rt_hit && rt_tn == TNEW_0) ? rt_k : '0;
    assign bus.illegal = bus.valid_in & dec_illegal;
    assign bus.a3_d    = dec_a3;

    // Nops and illegal words carry no destination, so they enter as bubbles too.
    assign bubble = stall | bus.flush | ~bus.valid_in | (dec_cls == ClsNop);

    // Next stage contents: D info into stage 1, others shift with tnew countdown.
    always_comb begin
        st_a3_d[0]   = bubble ? REG_ZERO : dec_a3;
        st_tnew_d[0] = bubble ? TNEW_0 : dec_tnew;
        for (int i = 1; i < DEPTH; i++) begin
            st_a3_d[i]   = st_a3_q[i-1];
            st_tnew_d[i] = tnew_dec(st_tnew_q[i-1]);
        end
    end

    // Stage registers with synchronous reset overriding all other inputs.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                st_a3_q[i]   <= REG_ZERO;
                st_tnew_q[i] <= TNEW_0;
            end else begin
                st_a3_q[i]   <= st_a3_d[i];
                st_tnew_q[i] <= st_tnew_d[i];
            end
        end
    end
endmodule

// File: tb/tb_decode_hazard_pipe.sv
// Directed bench: a DEPTH=3 and a DEPTH=4 instance share one stimulus stream.
module tb_decode_hazard_pipe;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] LW1      = 32'h8C01_0000; // lw  $1,0($0)
    localparam logic [31:0] LW5      = 32'h8C05_0000; // lw  $5,0($0)
    localparam logic [31:0] ADD2_11  = 32'h0021_1020; // add $2,$1,$1
    localparam logic [31:0] ADD3_45  = 32'h0085_1820; // add $3,$4,$5
    localparam logic [31:0] ADD1_23  = 32'h0043_0820; // add $1,$2,$3
    localparam logic [31:0] ADD4_10  = 32'h0020_2020; // add $4,$1,$0
    localparam logic [31:0] ADD0_12  = 32'h0022_0020; // add $0,$1,$2
    localparam logic [31:0] ADD3_00  = 32'h0000_1820; // add $3,$0,$0
    localparam logic [31:0] ADD6_55  = 32'h00A5_3020; // add $6,$5,$5
    localparam logic [31:0] BEQ3_0   = 32'h1060_0000; // beq $3,$0
    localparam logic [31:0] JAL      = 32'h0C00_0000;
    localparam logic [31:0] JR31     = 32'h03E0_0008;
    localparam logic [31:0] SW1      = 32'hAC01_0000; // sw  $1,0($0)
    localparam logic [31:0] BADOP    = 32'hFC00_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    decode_hazard_pipe_if #(.DEPTH(3)) if3 ();
    decode_hazard_pipe_if #(.DEPTH(4)) if4 ();

    decode_hazard_pipe #(.DEPTH(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));
    decode_hazard_pipe #(.DEPTH(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

    task automatic drive(input logic [31:0] w, input logic v, input logic f);
        if3.instr = w; if3.valid_in = v; if3.flush = f;
        if4.instr = w; if4.valid_in = v; if4.flush = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(NOP, 1'b1, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(LW1, 1'b1, 1'b0); // lw during reset must not be captured
        tick();
        reset = 1'b0;
        drive(ADD2_11, 1'b1, 1'b0);
        n_vec++; if (if3.stall !== 1'b0) begin n_err++;
            $display("FAIL reset_stall got %b want 0", if3.stall); end
        n_vec++; if (if3.fwd_rs !== 2'd0) begin n_err++;
            $display("FAIL reset_fwd_rs got %0d want 0", if3.fwd_rs); end
        n_vec++; if (if3.fwd_rt !== 2'd0) begin n_err++;
            $display("FAIL reset_fwd_rt got %0d want 0", if3.fwd_rt); end
    endtask

    task automatic test_decode();
        logic [31:0] w   [13];
        logic [4:0]  a3  [13];
        logic        ill [13];
        w = '{32'h00851820, 32'h00851822, JR31, NOP, 32'h34070005, LW5, SW1,
              BEQ3_0, 32'h3C080000, JAL, BADOP, 32'h00851821, 32'h00851800};
        a3 = '{5'd3, 5'd3, 5'd0, 5'd0, 5'd7, 5'd5, 5'd0, 5'd0, 5'd8, 5'd31,
               5'd0, 5'd0, 5'd0};
        ill = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(w[i], 1'b1, 1'b0);
            n_vec++; if (if3.a3_d !== a3[i]) begin n_err++;
                $display("FAIL decode_a3[%0d] got %0d want %0d", i, if3.a3_d, a3[i]); end
            n_vec++; if (if3.illegal !== ill[i]) begin n_err++;
                $display("FAIL decode_ill[%0d] got %b want %b", i, if3.illegal, ill[i]); end
        end
        drive(BADOP, 1'b0, 1'b0);
        n_vec++; if (if3.illegal !== 1'b0) begin n_err++;
            $display("FAIL decode_ill_invalid got %b want 0", if3.illegal); end
    endtask

    task automatic test_lw_use();
        do_reset();
        drive(LW1, 1'b1, 1'b0); tick();
        drive(ADD2_11, 1'b1, 1'b0);
        n_vec++; if (if3.stall !== 1'b1) begin n_err++;
            $display("FAIL lwuse_stall got %b want 1", if3.stall); end
        tick();
        n_vec++; if (if3.stall !== 1'b0) begin n_err++;
            $display("FAIL lwuse_release got %b want 0", if3.stall); end
        n_vec++; if ({if3.fwd_rs, if3.fwd_rt} !== 4'd0) begin n_err++;
            $display("FAIL lwuse_fwd got %0d/%0d want 0/0", if3.fwd_rs, if3.fwd_rt); end
        tick();
        drive(ADD4_10, 1'b1, 1'b0); // lw now in W with tnew 0
        n_vec++; if (if3.fwd_rs !== 2'd3) begin n_err++;
            $display("FAIL lwuse_fwd_w got %0d want 3", if3.fwd_rs); end
    endtask

    task automatic test_alu_branch();
        do_reset();
        drive(ADD3_45, 1'b1, 1'b0); tick();
        drive(BEQ3_0, 1'b1, 1'b0);
        n_vec++; if (if3.stall !== 1'b1) begin n_err++;
            $display("FAIL beq_stall got %b want 1", if3.stall); end
        tick();
        n_vec++; if (if3.stall !== 1'b0) begin n_err++;
            $display("FAIL beq_release got %b want 0", if3.stall); end
        n_vec++; if (if3.fwd_rs !== 2'd2) begin n_err++;
            $display("FAIL beq_fwd_rs got %0d want 2", if3.fwd_rs); end
        n_vec++; if (if3.fwd_rt !== 2'd0) begin n_err++;
            $display("FAIL beq_fwd_rt got %0d want 0", if3.fwd_rt); end
    endtask

    task automatic test_jal_jr();
        do_reset();
        drive(JAL, 1'b1, 1'b0); tick();
        drive(JR31, 1'b1, 1'b0);
        n_vec++; if (if3.stall !== 1'b0) begin n_err++;
            $display("FAIL jr_stall got %b want 0", if3.stall); end
        n_vec++; if (if3.fwd_rs !== 2'd1) begin n_err++;
            $display("FAIL jr_fwd_rs got %0d want 1", if3.fwd_rs); end
    endtask

    task automatic test_lw_sw();
        do_reset();
        drive(LW1, 1'b1, 1'b0); tick();
        drive(SW1, 1'b1, 1'b0);
        n_vec++; if (if3.stall !== 1'b0) begin n_err++;
            $display("FAIL lwsw_stall got %b want 0", if3.stall); end
        n_vec++; if (if3.fwd_rt !== 2'd0) begin n_err++;
            $display("FAIL lwsw_fwd_rt got %0d want 0", if3.fwd_rt); end
    endtask

    task automatic test_nearest();
        do_reset();
        drive(ADD1_23, 1'b1, 1'b0); tick();
        drive(LW1, 1'b1, 1'b0); tick(); // E={1,2}, M={1,0}
        drive(SW1, 1'b1, 1'b0);
        n_vec++; if (if3.stall !== 1'b0) begin n_err++;
            $display("FAIL near_sw_stall got %b want 0", if3.stall); end
        n_vec++; if (if3.fwd_rt !== 2'd0) begin n_err++;
            $display("FAIL near_sw_fwd_rt got %0d want 0", if3.fwd_rt); end
        drive(ADD2_11, 1'b1, 1'b0);
        n_vec++; if (if3.stall !== 1'b1) begin n_err++;
            $display("FAIL near_add_stall got %b want 1", if3.stall); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(ADD0_12, 1'b1, 1'b0); tick();
        drive(ADD3_00, 1'b1, 1'b0);
        n_vec++; if (if3.stall !== 1'b0) begin n_err++;
            $display("FAIL zero_stall got %b want 0", if3.stall); end
        n_vec++; if ({if3.fwd_rs, if3.fwd_rt} !== 4'd0) begin n_err++;
            $display("FAIL zero_fwd got %0d/%0d want 0/0", if3.fwd_rs, if3.fwd_rt); end
    endtask

    task automatic test_flush_valid();
        do_reset();
        drive(LW1, 1'b1, 1'b1); tick();
        drive(ADD2_11, 1'b1, 1'b0);
        n_vec++; if (if3.stall !== 1'b0) begin n_err++;
            $display("FAIL flush_stall got %b want 0", if3.stall); end
        do_reset();
        drive(LW1, 1'b0, 1'b0); tick();
        drive(ADD2_11, 1'b1, 1'b0);
        n_vec++; if (if3.stall !== 1'b0) begin n_err++;
            $display("FAIL invalid_prod_stall got %b want 0", if3.stall); end
        do_reset();
        drive(LW1, 1'b1, 1'b0); tick();
        drive(ADD2_11, 1'b0, 1'b0);
        n_vec++; if (if3.stall !== 1'b0) begin n_err++;
            $display("FAIL invalid_cons_stall got %b want 0", if3.stall); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(LW1, 1'b1, 1'b0); tick();
        drive(ADD2_11, 1'b1, 1'b1);
        n_vec++; if (if3.stall !== 1'b1) begin n_err++;
            $display("FAIL stflush_stall got %b want 1", if3.stall); end
        tick();
        drive(ADD2_11, 1'b1, 1'b0);
        n_vec++; if (if3.stall !== 1'b0) begin n_err++;
            $display("FAIL stflush_once got %b want 0", if3.stall); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(LW1, 1'b1, 1'b0); tick();
        drive(ADD2_11, 1'b1, 1'b0);
        n_vec++; if (if3.stall !== 1'b1) begin n_err++;
            $display("FAIL rstmid_pre got %b want 1", if3.stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_vec++; if (if3.stall !== 1'b0) begin n_err++;
            $display("FAIL rstmid_stall got %b want 0", if3.stall); end
        n_vec++; if ({if3.fwd_rs, if3.fwd_rt} !== 4'd0) begin n_err++;
            $display("FAIL rstmid_fwd got %0d/%0d want 0/0", if3.fwd_rs, if3.fwd_rt); end
        tick(); tick();
        drive(ADD4_10, 1'b1, 1'b0); // no lw residue may appear in W
        n_vec++; if (if3.fwd_rs !== 2'd0) begin n_err++;
            $display("FAIL rstmid_residue got %0d want 0", if3.fwd_rs); end
        drive(BADOP, 1'b1, 1'b0);
        n_vec++; if (if3.illegal !== 1'b1) begin n_err++;
            $display("FAIL rstmid_illegal got %b want 1", if3.illegal); end
        n_vec++; if (if3.stall !== 1'b0) begin n_err++;
            $display("FAIL rstmid_ill_stall got %b want 0", if3.stall); end
    endtask

    task automatic test_depth4();
        do_reset();
        drive(LW5, 1'b1, 1'b0); tick();
        for (int i = 0; i < 2; i++) begin
            drive(NOP, 1'b1, 1'b0);
            n_vec++; if (if4.stall !== 1'b0) begin n_err++;
                $display("FAIL d4_nop%0d_stall got %b want 0", i, if4.stall); end
            tick();
        end
        drive(ADD6_55, 1'b1, 1'b0);
        n_vec++; if (if4.stall !== 1'b0) begin n_err++;
            $display("FAIL d4_add_stall got %b want 0", if4.stall); end
        n_vec++; if (if4.fwd_rs !== 3'd3) begin n_err++;
            $display("FAIL d4_fwd_rs got %0d want 3", if4.fwd_rs); end
        n_vec++; if (if4.fwd_rt !== 3'd3) begin n_err++;
            $display("FAIL d4_fwd_rt got %0d want 3", if4.fwd_rt); end
        do_reset();
        drive(LW5, 1'b1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(NOP, 1'b1, 1'b0); tick();
        end
        drive(ADD6_55, 1'b1, 1'b0);
        n_vec++; if (if4.fwd_rs !== 3'd4) begin n_err++;
            $display("FAIL d4_fwd_k4 got %0d want 4", if4.fwd_rs); end
        n_vec++; if (if3.fwd_rs !== 2'd0) begin n_err++;
            $display("FAIL d3_fell_off got %0d want 0", if3.fwd_rs); end
    endtask

    initial begin
        drive(NOP, 1'b1, 1'b0);
        test_reset();
        test_decode();
        test_lw_use();
        test_alu_branch();
        test_jal_jr();
        test_lw_sw();
        test_nearest();
        test_zero_reg();
        test_flush_valid();
        test_stall_flush();
        test_reset_mid_stall();
        test_depth4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
